// File: rtl/spi_wrap_filter_pkg.sv
// rtl/spi_wrap_filter_pkg.sv - shared frame constants, field offsets and helpers for the wrap filter
package spi_wrap_filter_pkg;

  // Frame delimiter nibbles and the status-frame header
  localparam logic [3:0]  SOF_NIBBLE    = 4'hF;
  localparam logic [3:0]  EOF_NIBBLE    = 4'hF;
  localparam logic [15:0] STATUS_HEADER = 16'h57A7;

  // Command types carried by wrap frames
  typedef enum logic [1:0] {
    TYPE_NOP    = 2'd0,
    TYPE_WRITE  = 2'd1,
    TYPE_READ   = 2'd2,
    TYPE_UPDATE = 2'd3
  } frame_type_e;

  // Field offsets inside a 64-bit command beat
  localparam int ADDR_HI_LSB = 16;
  localparam int ADDR_HI_W   = 10;
  localparam int ADDR_LO_LSB = 36;
  localparam int ADDR_LO_W   = 12;
  localparam int SOF_LSB     = 28;
  localparam int EOF_LSB     = 48;

  // Filter control states
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  function automatic logic [21:0] get_addr(input logic [63:0] d);
    return {d[ADDR_HI_LSB +: ADDR_HI_W], d[ADDR_LO_LSB +: ADDR_LO_W]};
  endfunction

  function automatic logic [3:0] get_sof(input logic [63:0] d);
    return d[SOF_LSB +: 4];
  endfunction

  function automatic logic [3:0] get_eof(input logic [63:0] d);
    return d[EOF_LSB +: 4];
  endfunction

  // Counters stick at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/spi_wrap_filter_if.sv
// rtl/spi_wrap_filter_if.sv - 64-bit command stream bundle with tuser sideband
interface spi_wrap_filter_if;
  logic [63:0] tdata;
  logic [7:0]  tuser;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tuser, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/spi_axis_out_reg.sv
// rtl/spi_axis_out_reg.sv - single-entry output holding register with valid/ready drain
module spi_axis_out_reg (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        i_load,
  input  logic [63:0] i_tdata,
  input  logic [7:0]  i_tuser,
  input  logic        i_tready,
  output logic        o_tvalid,
  output logic [63:0] o_tdata,
  output logic [7:0]  o_tuser
);

  logic        r_valid;
  logic [63:0] r_data;
  logic [7:0]  r_user;

  // Load wins over drain so a same-cycle drain and reload stays valid with no bubble
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_valid <= 1'b0;
      r_data  <= 64'd0;
      r_user  <= 8'd0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_tdata;
      r_user  <= i_tuser;
    end else if (i_tready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_tvalid = r_valid;
  assign o_tdata  = r_data;
  assign o_tuser  = r_user;

endmodule

// File: rtl/spi_wrap_filter.sv
// rtl/spi_wrap_filter.sv - wrap command filter; SPI_WRAP_FILTER_PASSTHRU_EN forwards non-matching beats on p_axis
module spi_wrap_filter
  import spi_wrap_filter_pkg::*;
#(
  parameter logic [15:0] HEADER     = 16'h57A5,
  parameter logic [21:0] ADDR_MASK  = 22'h3FFFFC,
  parameter logic [21:0] ADDR_MATCH = 22'h000000
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  spi_wrap_filter_if.slave         s_axis,
  spi_wrap_filter_if.master        m_axis,
  spi_wrap_filter_if.master        p_axis,
  output logic [15:0]              err_count_o,
  output logic [15:0]              miss_count_o
);

  state_e      r_state;
  logic [15:0] r_err_count;
  logic [15:0] r_miss_count;

  logic        w_s_ready;
  logic        w_accept;
  logic        w_well_formed;
  logic        w_match;
  logic        w_m_ok;
  logic        w_p_ok;
  logic        w_load_m;
  logic        w_load_p;
  logic [21:0] w_addr;

  assign w_addr        = get_addr(s_axis.tdata);
  assign w_well_formed = (s_axis.tdata[15:0] == HEADER) &&
                         (get_sof(s_axis.tdata) == SOF_NIBBLE) &&
                         (get_eof(s_axis.tdata) == EOF_NIBBLE) &&
                         s_axis.tlast;
  assign w_match       = ((w_addr & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK));

  assign w_m_ok = !m_axis.tvalid || m_axis.tready;
`ifdef SPI_WRAP_FILTER_PASSTHRU_EN
  assign w_p_ok = !p_axis.tvalid || p_axis.tready;
`else
  assign w_p_ok = 1'b1;
`endif

  // Input ready depends on state: blocked in RESET, output space in IDLE, always in DROP
  always_comb begin
    w_s_ready = 1'b0;
    case (r_state)
      ST_IDLE: w_s_ready = w_m_ok && w_p_ok;
      ST_DROP: w_s_ready = 1'b1;
      default: w_s_ready = 1'b0;
    endcase
  end

  assign s_axis.tready = w_s_ready;
  assign w_accept      = s_axis.tvalid && w_s_ready;

  assign w_load_m = (r_state == ST_IDLE) && w_accept && w_well_formed && w_match;
`ifdef SPI_WRAP_FILTER_PASSTHRU_EN
  assign w_load_p = (r_state == ST_IDLE) && w_accept && w_well_formed && !w_match;
`else
  assign w_load_p = 1'b0;
`endif

  // Filter state machine plus the saturating error and miss counters
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= ST_RESET;
      r_err_count  <= 16'd0;
      r_miss_count <= 16'd0;
    end else begin
      case (r_state)
        ST_RESET: r_state <= ST_IDLE;
        ST_IDLE: begin
          if (w_accept) begin
            if (!s_axis.tlast) begin
              r_state     <= ST_DROP;
              r_err_count <= sat_inc(r_err_count);
            end else if (!w_well_formed) begin
              r_err_count <= sat_inc(r_err_count);
            end
`ifndef SPI_WRAP_FILTER_PASSTHRU_EN
            else if (!w_match) begin
              r_miss_count <= sat_inc(r_miss_count);
            end
`endif
          end
        end
        ST_DROP: begin
          if (w_accept && s_axis.tlast) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_RESET;
      endcase
    end
  end

  assign err_count_o  = r_err_count;
  assign miss_count_o = r_miss_count;

  spi_axis_out_reg u_m_reg (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .i_load   (w_load_m),
    .i_tdata  (s_axis.tdata),
    .i_tuser  (s_axis.tuser),
    .i_tready (m_axis.tready),
    .o_tvalid (m_axis.tvalid),
    .o_tdata  (m_axis.tdata),
    .o_tuser  (m_axis.tuser)
  );

  spi_axis_out_reg u_p_reg (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .i_load   (w_load_p),
    .i_tdata  (s_axis.tdata),
    .i_tuser  (s_axis.tuser),
    .i_tready (p_axis.tready),
    .o_tvalid (p_axis.tvalid),
    .o_tdata  (p_axis.tdata),
    .o_tuser  (p_axis.tuser)
  );

  assign m_axis.tlast = 1'b1;
  assign p_axis.tlast = 1'b1;

endmodule
